// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle for serial_subtractor.
// SERIAL_SUB_OVF_EN adds the two's-complement overflow flag ovf.
`timescale 1ns / 1ps

interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
`else
    modport master (output start, a, b, bin, input busy, done, diff, bout);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the two's-complement overflow output ovf.
`timescale 1ns / 1ps

module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);
    // One extra bit so the counter cannot wrap when WIDTH is a power of two.
    localparam int              CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic d_bit;
    logic brw_nxt;
    logic accept;

    // Full-subtractor cell on the current LSBs.
    assign d_bit   = a_q[0] ^ b_q[0] ^ brw_q;
    assign brw_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
    assign accept  = bus.start && (state_q != S_RUN);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        brw_d   = brw_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif

        case (state_q)
            S_IDLE: ;
            S_RUN: begin
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                res_d = {d_bit, res_q[WIDTH-1:1]};
                brw_d = brw_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    diff_d  = res_d;
                    bout_d  = brw_nxt;
`ifdef SERIAL_SUB_OVF_EN
                    // brw_q is the borrow into the MSB on this final bit.
                    ovf_d   = brw_q ^ brw_nxt;
`endif
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Accepted start in IDLE or DONE overrides the default transition.
        if (accept) begin
            state_d = S_RUN;
            a_d     = bus.a;
            b_d     = bus.b;
            brw_d   = bus.bin;
            cnt_d   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=4 and WIDTH=8 instances).
// Overflow checks are compiled in with SERIAL_SUB_OVF_EN.
`timescale 1ns / 1ps

module tb_serial_subtractor;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   done4;

    serial_subtractor_if #(.WIDTH(4)) bus4 ();
    serial_subtractor_if #(.WIDTH(8)) bus8 ();

    serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Samples done as it stood before each rising edge.
    always @(posedge clk) if (bus4.done === 1'b1) done4++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge inside RUN or DONE; stops at the negedge where done is high.
    task automatic wait_done4(output bit seen, output int lat, output int busy_cycles);
        seen = 1'b0;
        lat = 0;
        busy_cycles = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            if (bus4.done === 1'b1) begin
                seen = 1'b1;
                lat  = i;
            end else begin
                if (bus4.busy === 1'b1) busy_cycles++;
                @(negedge clk);
            end
        end
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                       input string tag);
        bit seen;
        int lat;
        int busy_cycles;
        @(negedge clk);
        bus4.a     = a;
        bus4.b     = b;
        bus4.bin   = bin;
        bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        wait_done4(seen, lat, busy_cycles);
        check({tag, "_done_seen"}, 32'(seen), 1);
        check({tag, "_latency"}, lat, 5);
        check({tag, "_busy_cycles"}, busy_cycles, 4);
    endtask

    initial begin
        bit seen;
        int lat;
        int busy_cycles;
        int d0;

        errors = 0;
        checks = 0;
        done4  = 0;
        rst_n  = 1'b0;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;

        #1;
        check("rst_busy", bus4.busy, 0);
        check("rst_done", bus4.done, 0);
        check("rst_diff", bus4.diff, 0);
        check("rst_bout", bus4.bout, 0);
        check("rst_diff8", bus8.diff, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: 7 - 3 = 4
        op4(4'd7, 4'd3, 1'b0, "t1");
        check("t1_diff", bus4.diff, 4);
        check("t1_bout", bus4.bout, 0);
        @(negedge clk);
        check("t1_done_one_cycle", bus4.done, 0);
        check("t1_idle_busy", bus4.busy, 0);
        check("t1_hold_diff", bus4.diff, 4);

        // 2: underflow cases
        op4(4'd3, 4'd7, 1'b0, "t2a");
        check("t2a_diff", bus4.diff, 12);
        check("t2a_bout", bus4.bout, 1);
        op4(4'd0, 4'd0, 1'b1, "t2b");
        check("t2b_diff", bus4.diff, 15);
        check("t2b_bout", bus4.bout, 1);

        // 3: start during RUN is ignored
        @(negedge clk);
        bus4.a = 4'd9; bus4.b = 4'd2; bus4.bin = 1'b0; bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        check("t3_busy", bus4.busy, 1);
        check("t3_hold_in_run", bus4.diff, 15);
        d0 = done4;
        @(negedge clk);
        bus4.a = 4'd1; bus4.b = 4'd1; bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        wait_done4(seen, lat, busy_cycles);
        check("t3_done_seen", 32'(seen), 1);
        check("t3_diff", bus4.diff, 7);
        check("t3_bout", bus4.bout, 0);
        repeat (8) @(negedge clk);
        check("t3_done_count", done4 - d0, 1);

        // 4: reset in the second RUN cycle
        bus4.a = 4'd6; bus4.b = 4'd1; bus4.bin = 1'b0; bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        d0 = done4;
        @(negedge clk);
        check("t4_busy_before", bus4.busy, 1);
        rst_n = 1'b0;
        #1;
        check("t4_rst_busy", bus4.busy, 0);
        check("t4_rst_done", bus4.done, 0);
        check("t4_rst_diff", bus4.diff, 0);
        check("t4_rst_bout", bus4.bout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("t4_no_done", done4 - d0, 0);
        op4(4'd6, 4'd1, 1'b0, "t4b");
        check("t4b_diff", bus4.diff, 5);
        check("t4b_bout", bus4.bout, 0);

        // 5: start held through DONE starts the next op with no IDLE cycle
        @(negedge clk);
        bus4.a = 4'd10; bus4.b = 4'd3; bus4.bin = 1'b0; bus4.start = 1'b1;
        @(negedge clk);
        bus4.a = 4'd5; bus4.b = 4'd5;
        wait_done4(seen, lat, busy_cycles);
        check("t5a_done_seen", 32'(seen), 1);
        check("t5a_diff", bus4.diff, 7);
        @(negedge clk);
        check("t5_back_to_back_busy", bus4.busy, 1);
        check("t5_back_to_back_done", bus4.done, 0);
        bus4.start = 1'b0;
        wait_done4(seen, lat, busy_cycles);
        check("t5b_done_seen", 32'(seen), 1);
        check("t5b_latency", lat, 5);
        check("t5b_diff", bus4.diff, 0);
        check("t5b_bout", bus4.bout, 0);

`ifdef SERIAL_SUB_OVF_EN
        // 6: signed overflow flag
        op4(4'd8, 4'd1, 1'b0, "t6a");
        check("t6a_diff", bus4.diff, 7);
        check("t6a_ovf", bus4.ovf, 1);
        op4(4'd2, 4'd1, 1'b0, "t6b");
        check("t6b_diff", bus4.diff, 1);
        check("t6b_ovf", bus4.ovf, 0);
`endif

        // WIDTH=8: 200 - 100 = 100
        @(negedge clk);
        bus8.a = 8'd200; bus8.b = 8'd100; bus8.bin = 1'b0; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 30 && !seen; i++) begin
            if (bus8.done === 1'b1) begin
                seen = 1'b1;
                lat  = i;
            end else begin
                @(negedge clk);
            end
        end
        check("w8_done_seen", 32'(seen), 1);
        check("w8_latency", lat, 9);
        check("w8_diff", bus8.diff, 100);
        check("w8_bout", bus8.bout, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("w8_ovf", bus8.ovf, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
